// File: rtl/frame_pkg.sv
// frame_pkg: shared frame geometry, byte codes and router FSM states
package frame_pkg;
  localparam int DATA_SIZE = 64;
  localparam int PREAMBLE_SIZE = 7;
  localparam int CRC_SIZE = 4;
  localparam int FRAME_W = (PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE) * 8;
  localparam logic [7:0] FIRST_FRAME = 8'h00;
  localparam logic [7:0] LAST_FRAME = 8'h01;
  localparam logic [7:0] NORMALNA = 8'h02;
  localparam logic [7:0] POJEDYNCZA = 8'h03;
  localparam logic [7:0] FRAME_START = 8'h06;
  localparam logic [7:0] FRAME_END = 8'h07;
  localparam logic [7:0] ESC_VAL = 8'h14;
  localparam logic [7:0] ESC_XOR = 8'h20;
  localparam logic [7:0] OKAY = 8'h05;
  localparam logic [7:0] ERROR = 8'h04;
  localparam logic [7:0] FATAL_ERROR = 8'h08;
  typedef enum logic [2:0] {IDLE, CHECK, SEND, WAIT, REPORT} state_t;
endpackage

// File: rtl/frame_router_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter; priority starts just after last_grant
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  int idx;
  logic found;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && |(req & (N'(1) << idx))) begin
        found = 1'b1;
        grant = N'(1) << idx;
        grant_idx = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/frame_router.sv
// frame_router: round-robin N-channel frame switch awaiting PC confirmation,
// with retry on ERROR/timeout and a single final code back to the source.
module frame_router #(
  parameter int NUM_CH = 2,
  parameter int DATA_SIZE = frame_pkg::DATA_SIZE,
  parameter int PREAMBLE_SIZE = frame_pkg::PREAMBLE_SIZE,
  parameter int CRC_SIZE = frame_pkg::CRC_SIZE,
  parameter int FRAME_W = (PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE) * 8,
  parameter int DEST_BYTE = 2,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*FRAME_W-1:0] in_frame,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  output logic [FRAME_W-1:0]        out_frame,
  output logic [NUM_CH-1:0]         out_valid,
  input  logic [NUM_CH-1:0]         out_ready,
  input  logic [NUM_CH*8-1:0]       pc_conf,
  input  logic [NUM_CH-1:0]         pc_conf_valid,
  output logic [7:0]                conf_code,
  output logic [NUM_CH-1:0]         conf_valid,
  output logic                      busy
);
  import frame_pkg::*;
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  state_t state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CW-1:0] src_q, src_d, dest_q, dest_d, last_q, last_d, grant_idx;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] code_q, code_d, dest_byte, pc_sel;
  logic [NUM_CH-1:0] grant;
  logic bad_dest, pc_hit;
  rr_arbiter #(.N(NUM_CH), .IW(CW)) u_arb (
    .req(in_valid),
    .last_grant(last_q),
    .grant(grant),
    .grant_idx(grant_idx)
  );
  assign dest_byte = frame_q[FRAME_W-1-8*DEST_BYTE -: 8];
  assign bad_dest = int'(dest_byte) >= NUM_CH || dest_byte[CW-1:0] == src_q;
  assign pc_sel = 8'(pc_conf >> (8 * dest_q));
  assign pc_hit = pc_conf_valid[dest_q];
  assign in_ready = (rst_n && state_q == IDLE) ? grant : '0;
  assign out_frame = frame_q;
  assign out_valid = state_q == SEND ? NUM_CH'(1) << dest_q : '0;
  assign conf_valid = state_q == REPORT ? NUM_CH'(1) << src_q : '0;
  assign conf_code = state_q == REPORT ? code_q : 8'h00;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    src_d = src_q;
    dest_d = dest_q;
    last_d = last_q;
    retry_d = retry_q;
    timer_d = timer_q;
    code_d = code_q;
    case (state_q)
      IDLE: if (|in_valid) begin
        frame_d = FRAME_W'(in_frame >> (FRAME_W * grant_idx));
        src_d = grant_idx;
        state_d = CHECK;
      end
      CHECK: begin
        dest_d = dest_byte[CW-1:0];
        retry_d = '0;
        code_d = FATAL_ERROR;
        state_d = bad_dest ? REPORT : SEND;
      end
      SEND: if (out_ready[dest_q]) begin
        timer_d = TW'(TIMEOUT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q - 1'b1;
        // OKAY takes precedence over a timeout expiring in the same cycle
        if (pc_hit && pc_sel == OKAY) begin
          code_d = OKAY;
          state_d = REPORT;
        end else if (pc_hit || timer_q == '0) begin
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
          end else begin
            code_d = FATAL_ERROR;
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        last_d = src_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      src_q <= '0;
      dest_q <= '0;
      last_q <= CW'(NUM_CH - 1);
      retry_q <= '0;
      timer_q <= '0;
      code_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      src_q <= src_d;
      dest_q <= dest_d;
      last_q <= last_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      code_q <= code_d;
    end
  end
endmodule

// File: tb/tb_frame_router.sv
// tb_frame_router: directed checks of routing, retry, timeout, arbitration and reset
module tb_frame_router;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  logic b_rst_n, c_rst_n;
  logic [2399:0] b_in_frame;
  logic [3:0] b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_pc_conf_valid, b_conf_valid;
  logic [599:0] b_out_frame, c_out_frame, fr;
  logic [31:0] b_pc_conf;
  logic [7:0] b_conf_code, c_conf_code;
  logic b_busy, c_busy;
  logic [1199:0] c_in_frame;
  logic [1:0] c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_pc_conf_valid, c_conf_valid;
  logic [15:0] c_pc_conf;
  logic [3:0] fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  frame_router #(.NUM_CH(4), .MAX_RETRY(3), .TIMEOUT(16)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in_frame(b_in_frame), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_frame(b_out_frame), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .pc_conf(b_pc_conf), .pc_conf_valid(b_pc_conf_valid),
    .conf_code(b_conf_code), .conf_valid(b_conf_valid), .busy(b_busy)
  );
  frame_router #(.NUM_CH(2), .MAX_RETRY(0), .TIMEOUT(16)) u_c (
    .clk(clk), .rst_n(c_rst_n), .in_frame(c_in_frame), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_frame(c_out_frame), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .pc_conf(c_pc_conf), .pc_conf_valid(c_pc_conf_valid),
    .conf_code(c_conf_code), .conf_valid(c_conf_valid), .busy(c_busy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [599:0] mk(input logic [7:0] d, input logic [7:0] s);
    logic [599:0] f;
    for (int k = 0; k < 75; k++) f[599-8*k -: 8] = 8'(k) ^ s;
    f[583 -: 8] = d;
    return f;
  endfunction
  initial begin
    b_rst_n = 1'b0;
    c_rst_n = 1'b0;
    b_in_frame = {4{mk(8'h01, 8'h11)}};
    c_in_frame = {2{mk(8'h01, 8'h22)}};
    b_in_valid = '1; b_out_ready = '1; b_pc_conf = '1; b_pc_conf_valid = '1;
    c_in_valid = '1; c_out_ready = '1; c_pc_conf = {8'h05, 8'h05}; c_pc_conf_valid = '1;
    repeat (3) step();
    chk("rst_c_in_ready", c_in_ready, 0);
    chk("rst_c_out_valid", c_out_valid, 0);
    chk("rst_c_out_frame", c_out_frame, 0);
    chk("rst_c_conf_valid", c_conf_valid, 0);
    chk("rst_c_conf_code", c_conf_code, 0);
    chk("rst_c_busy", c_busy, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_conf_valid", b_conf_valid, 0);
    chk("rst_b_busy", b_busy, 0);
    b_in_valid = '0; b_out_ready = '0; b_pc_conf = '0; b_pc_conf_valid = '0;
    c_in_valid = '0; c_out_ready = '0; c_pc_conf = '0; c_pc_conf_valid = '0;
    b_rst_n = 1'b1;
    c_rst_n = 1'b1;
    step();
    // happy path: ch0 -> ch1, foreign strobe from ch0 must be ignored
    fr = mk(8'h01, 8'hA0);
    c_in_frame[0 +: 600] = fr; c_in_valid = 2'b01; #1;
    chk("hp_in_ready", c_in_ready, 2'b01);
    chk("hp_ov_accept", c_out_valid, 0);
    step(); c_in_valid = '0;
    chk("hp_busy", c_busy, 1);
    chk("hp_ov_check", c_out_valid, 0);
    step();
    chk("hp_out_valid", c_out_valid, 2'b10);
    chk("hp_out_frame", c_out_frame, fr);
    c_out_ready = 2'b10; step(); c_out_ready = '0;
    chk("hp_ov_drop", c_out_valid, 0);
    c_pc_conf = {8'h00, 8'h04}; c_pc_conf_valid = 2'b01; step();
    chk("hp_foreign_ignored", c_conf_valid, 0);
    chk("hp_still_busy", c_busy, 1);
    c_pc_conf = {8'h05, 8'h00}; c_pc_conf_valid = 2'b10; step(); c_pc_conf_valid = '0;
    chk("hp_conf_valid", c_conf_valid, 2'b01);
    chk("hp_conf_code", c_conf_code, 8'h05);
    step();
    chk("hp_idle", c_busy, 0);
    chk("hp_conf_clear", c_conf_valid, 0);
    // timeout: ch1 -> ch0, PC silent, MAX_RETRY=0
    fr = mk(8'h00, 8'h5C);
    c_in_frame[600 +: 600] = fr; c_in_valid = 2'b10; #1;
    chk("to_in_ready", c_in_ready, 2'b10);
    step(); c_in_valid = '0;
    step();
    chk("to_out_valid", c_out_valid, 2'b01);
    chk("to_out_frame", c_out_frame, fr);
    c_out_ready = 2'b01; step(); c_out_ready = '0;
    repeat (15) step();
    chk("to_not_yet", c_conf_valid, 0);
    chk("to_busy", c_busy, 1);
    step();
    chk("to_conf_valid", c_conf_valid, 2'b10);
    chk("to_conf_code", c_conf_code, 8'h08);
    step();
    // OKAY in the final timer cycle wins over the timeout
    fr = mk(8'h01, 8'h3B);
    c_in_frame[0 +: 600] = fr; c_in_valid = 2'b01; #1;
    chk("ok_to_in_ready", c_in_ready, 2'b01);
    step(); c_in_valid = '0;
    step();
    chk("ok_to_out_valid", c_out_valid, 2'b10);
    c_out_ready = 2'b10; step(); c_out_ready = '0;
    repeat (15) step();
    c_pc_conf = {8'h05, 8'h00}; c_pc_conf_valid = 2'b10; step(); c_pc_conf_valid = '0;
    chk("ok_to_conf_valid", c_conf_valid, 2'b01);
    chk("ok_to_conf_code", c_conf_code, 8'h05);
    step();
    // reset while waiting abandons the frame silently
    fr = mk(8'h01, 8'h77);
    c_in_frame[0 +: 600] = fr; c_in_valid = 2'b01; step(); c_in_valid = '0;
    step();
    chk("rw_out_valid", c_out_valid, 2'b10);
    c_out_ready = 2'b10; step(); c_out_ready = '0;
    repeat (3) step();
    c_rst_n = 1'b0; step();
    chk("rw_conf_valid", c_conf_valid, 0);
    chk("rw_out_valid_rst", c_out_valid, 0);
    chk("rw_busy", c_busy, 0);
    step(); c_rst_n = 1'b1;
    c_pc_conf = {8'h05, 8'h00}; c_pc_conf_valid = 2'b10; step(); c_pc_conf_valid = '0;
    chk("rw_late_conf", c_conf_valid, 0);
    chk("rw_idle", c_busy, 0);
    fr = mk(8'h00, 8'h99);
    c_in_frame[600 +: 600] = fr; c_in_valid = 2'b10; #1;
    chk("rw_next_in_ready", c_in_ready, 2'b10);
    step(); c_in_valid = '0;
    step();
    chk("rw_next_out_valid", c_out_valid, 2'b01);
    chk("rw_next_frame", c_out_frame, fr);
    c_out_ready = 2'b01; step(); c_out_ready = '0;
    c_pc_conf = {8'h00, 8'h05}; c_pc_conf_valid = 2'b01; step(); c_pc_conf_valid = '0;
    chk("rw_next_conf_valid", c_conf_valid, 2'b10);
    chk("rw_next_conf_code", c_conf_code, 8'h05);
    // retry exhaustion: ch2 -> ch3, PC always answers ERROR
    fr = mk(8'h03, 8'hC2);
    b_in_frame[1200 +: 600] = fr; b_in_valid = 4'b0100; #1;
    chk("rt_in_ready", b_in_ready, 4'b0100);
    step(); b_in_valid = '0;
    step();
    for (int a = 0; a < 4; a++) begin
      chk("rt_out_valid", b_out_valid, 4'b1000);
      chk("rt_out_frame", b_out_frame, fr);
      chk("rt_no_conf", b_conf_valid, 0);
      b_out_ready = 4'b1000; step(); b_out_ready = '0;
      chk("rt_ov_drop", b_out_valid, 0);
      b_pc_conf[24 +: 8] = 8'h04; b_pc_conf_valid = 4'b1000; step(); b_pc_conf_valid = '0;
    end
    chk("rt_conf_valid", b_conf_valid, 4'b0100);
    chk("rt_conf_code", b_conf_code, 8'h08);
    chk("rt_no_fifth", b_out_valid, 0);
    step();
    chk("rt_idle", b_busy, 0);
    // invalid destination: byte 2 = 5 with 4 channels
    b_in_frame[600 +: 600] = mk(8'h05, 8'h1D); b_in_valid = 4'b0010; #1;
    chk("id_in_ready", b_in_ready, 4'b0010);
    step(); b_in_valid = '0;
    chk("id_check_ov", b_out_valid, 0);
    chk("id_check_cv", b_conf_valid, 0);
    step();
    chk("id_conf_valid", b_conf_valid, 4'b0010);
    chk("id_conf_code", b_conf_code, 8'h08);
    chk("id_no_forward", b_out_valid, 0);
    step();
    // destination equal to source is rejected too
    b_in_frame[0 +: 600] = mk(8'h00, 8'h4E); b_in_valid = 4'b0001; #1;
    chk("ds_in_ready", b_in_ready, 4'b0001);
    step(); b_in_valid = '0;
    step();
    chk("ds_conf_valid", b_conf_valid, 4'b0001);
    chk("ds_conf_code", b_conf_code, 8'h08);
    chk("ds_no_forward", b_out_valid, 0);
    step();
    // fairness with every channel requesting continuously
    b_rst_n = 1'b0; step(); b_rst_n = 1'b1;
    b_in_frame = {4{mk(8'h05, 8'hF0)}}; b_in_valid = 4'hF; #1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_in_ready", b_in_ready, fair_exp[g]);
      step();
      chk("rr_busy_ready", b_in_ready, 0);
      step();
      chk("rr_conf_valid", b_conf_valid, fair_exp[g]);
      step();
    end
    b_in_valid = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frame_router.md
Name: frame_router

Overview:
- N-channel successor to the fixed two-port (jawny/tajny) frame core.
- Accepts complete de-stuffed frames from NUM_CH channel interfaces and round-robin arbitrates between them.
- Forwards each frame to the destination channel named in its header, then waits for that channel's PC confirmation.
- Retries on ERROR or timeout and returns one final confirmation code (OKAY / FATAL_ERROR) to the source channel.

Parameters:
- NUM_CH, 2, number of channel interfaces (2..8).
- DATA_SIZE, 64, payload bytes per frame.
- PREAMBLE_SIZE, 7, header bytes per frame.
- CRC_SIZE, 4, CRC bytes per frame.
- FRAME_W, (PREAMBLE_SIZE+DATA_SIZE+CRC_SIZE)*8, frame width in bits (600).
- DEST_BYTE, 2, header byte index holding the destination channel number.
- MAX_RETRY, 3, retransmissions after the first send before FATAL_ERROR.
- TIMEOUT, 1_000_000, clk cycles to wait for a PC confirmation.
- OKAY / ERROR / FATAL_ERROR, 8'h05 / 8'h04 / 8'h08, confirmation codes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- in_frame  in  NUM_CH*FRAME_W  received frames; channel i at [i*FRAME_W +: FRAME_W]
- in_valid  in  NUM_CH  frame i available
- in_ready  out  NUM_CH  frame i accepted this cycle
- out_frame  out  FRAME_W  frame being forwarded (shared bus)
- out_valid  out  NUM_CH  one-hot; out_frame offered to channel i
- out_ready  in  NUM_CH  channel i has taken out_frame
- pc_conf  in  NUM_CH*8  confirmation byte from PC behind channel i
- pc_conf_valid  in  NUM_CH  1-cycle strobe for pc_conf of channel i
- conf_code  out  8  code returned to the source channel
- conf_valid  out  NUM_CH  one-hot 1-cycle strobe; conf_code is for channel i
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset:
  - Single clock domain clk; reset rst_n is synchronous, active-low.
  - All registers update on the rising edge of clk only.
- Reset values:
  - All outputs 0 (out_frame 0, conf_code 8'h00).
  - FSM in IDLE, retry counter 0, timer 0, last_grant = NUM_CH-1 (so channel 0 wins first).
  - Reset mid-operation abandons the held frame silently: no conf_valid, no out_valid.
- Frame byte k is bits [FRAME_W-1-8k -: 8], so byte 0 is the MSB byte.
- Arbitration:
  - Round-robin starting at last_grant+1, wrapping modulo NUM_CH.
  - in_ready is combinational, high only in IDLE and only for the winning channel.
  - A transfer occurs when in_valid[i] && in_ready[i]. The frame is captured into the holding register and src=i; next state is CHECK.
- FSM:
  - IDLE: wait for any in_valid.
  - CHECK (1 cycle): dest = frame byte DEST_BYTE.
    - If dest >= NUM_CH or dest == src, go to REPORT with FATAL_ERROR; nothing is forwarded.
    - Otherwise clear the retry counter and go to SEND.
  - SEND: out_frame = held frame and out_valid[dest] = 1, held until out_ready[dest]. In that cycle, drop out_valid, load timer = TIMEOUT-1 and go to WAIT.
  - WAIT: timer decrements each cycle. Only pc_conf_valid[dest] is observed; strobes from other channels are ignored and dropped.
    - pc_conf == OKAY: go to REPORT with OKAY.
    - Any other code, or timer == 0: if retry < MAX_RETRY, increment retry and go to SEND; else go to REPORT with FATAL_ERROR.
    - OKAY arriving in the same cycle the timer reaches 0: OKAY wins.
  - REPORT (1 cycle): conf_valid[src] = 1 with conf_code; last_grant = src; go to IDLE.
- Latency:
  - Accept to out_valid: 2 cycles.
  - PC confirm to conf_valid: 1 cycle.
  - Invalid destination: conf_valid 2 cycles after accept.
- Channel independence: in_valid of other channels is ignored (in_ready low) while busy. A channel may be both src of one transfer and dest of the next.
- Widths:
  - Timer is $clog2(TIMEOUT+1) bits.
  - Retry counter is $clog2(MAX_RETRY+1) bits.
  - Channel indices are $clog2(NUM_CH) bits, with a minimum of 1.

Decomposition:
- Package frame_pkg holds:
  - The size parameters and FRAME_W formula.
  - Frame type codes (FIRST_FRAME 00, LAST_FRAME 01, NORMALNA 02, POJEDYNCZA 03).
  - Flags (FRAME_START 06, FRAME_END 07, ESC_VAL 14, ESC_XOR 20).
  - Confirmation codes and the FSM state enum.
- One sub-module, rr_arbiter (NUM_CH request vector plus last_grant in; one-hot grant and index out), is combinational and reused by future multi-channel blocks.

Test Plan:
- Reset: drive rst_n=0 for 3 cycles with all inputs active; all outputs 0 and busy=0.
- Happy path:
  - Stimulus: NUM_CH=2; ch0 presents a frame with byte 2 = 8'h01; ch1 returns pc_conf=8'h05.
  - Response: out_valid=2'b10 two cycles after accept; out_frame equals the input frame; conf_valid=2'b01 with conf_code 8'h05 one cycle later.
- Retry exhaustion:
  - Stimulus: NUM_CH=4, MAX_RETRY=3; ch2 sends to dest 3; PC answers 8'h04 every time.
  - Response: exactly 4 out_valid handshakes on ch3, then conf_valid[2] with 8'h08.
- Timeout:
  - Stimulus: TIMEOUT=16, MAX_RETRY=0; the PC never answers.
  - Response: conf_valid[src] with 8'h08 exactly 16 cycles after the out_ready handshake.
- Invalid destination and fairness:
  - Invalid destination: byte 2 = 8'h05 with NUM_CH=4 gives no out_valid and 8'h08 two cycles after accept.
  - Fairness: all in_valid held high, grants go 0,1,2,3,0.
- Edge cases:
  - OKAY strobe arriving in the same cycle as timeout returns 8'h05.
  - rst_n low during WAIT gives no conf_valid; the next frame then routes normally.
